// File: rtl/hs_rr_arbiter_if.sv
// hs_rr_arbiter_if: N request channels merged onto one shared valid/ready slave channel
interface hs_rr_arbiter_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   logic [N-1:0]    m_valid;
   logic [N*DW-1:0] m_data;
   logic [N-1:0]    m_ready;
   logic            s_valid;
   logic [DW-1:0]   s_data;
   logic            s_ready;
   modport master (
      output m_valid, m_data, s_ready,
      input  m_ready, s_valid, s_data
   );
   modport slave (
      input  m_valid, m_data, s_ready,
      output m_ready, s_valid, s_data
   );
endinterface

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin burst arbiter, one master owns the slave until it drops valid or hits MAX_BEATS
module hs_rr_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hs_rr_arbiter_if.slave bus,
   output logic [N-1:0] grant,
   output logic         busy
);
   localparam int IW = $clog2(N);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state, state_nx;
   logic [IW-1:0] rr_ptr, rr_ptr_nx, g, g_nx, pick;
   logic [N-1:0]  grant_nx;
   logic [7:0]    beat_cnt, beat_cnt_inc, beat_cnt_nx;
   logic          found, beat, forced, release_req;
   assign busy = state == BUSY;
   always_comb begin
      bus.s_valid = busy & bus.m_valid[g];
      bus.s_data  = (busy & bus.m_valid[g]) ? bus.m_data[g*DW +: DW] : '0;
      bus.m_ready = grant & {N{bus.s_ready}};
   end
   // Scan downward so the last hit written is the nearest set bit at or above rr_ptr.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.m_valid[(int'(rr_ptr) + i) % N]) begin
            found = 1'b1;
            pick  = IW'((int'(rr_ptr) + i) % N);
         end
      end
   end
   assign beat         = bus.s_valid & bus.s_ready;
   assign beat_cnt_inc = (beat && beat_cnt != 8'hFF) ? beat_cnt + 8'd1 : beat_cnt;
   assign forced       = beat && beat_cnt_inc == 8'(MAX_BEATS);
   assign release_req  = !bus.m_valid[g];
   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      g_nx        = g;
      rr_ptr_nx   = rr_ptr;
      beat_cnt_nx = beat_cnt_inc;
      if (state == IDLE) begin
         if (found) begin
            state_nx    = BUSY;
            g_nx        = pick;
            grant_nx    = {{(N-1){1'b0}}, 1'b1} << pick;
            beat_cnt_nx = '0;
         end
      end else if (release_req || forced) begin
         state_nx  = IDLE;
         grant_nx  = '0;
         rr_ptr_nx = (g == IW'(N - 1)) ? '0 : g + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         g        <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         g        <= g_nx;
         rr_ptr   <= rr_ptr_nx;
         beat_cnt <= beat_cnt_nx;
      end
   end
endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesting masters (2..8).
REQ-002 Parameter DW, default 32, SHALL set the data width per beat.
REQ-003 Parameter MAX_BEATS, default 16, SHALL set the maximum beats per grant (1..255).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 m_valid  input  N  SHALL carry the per-master valid; bit i belongs to master i.
REQ-007 m_data  input  N*DW  SHALL carry the per-master data; master i occupies bits [i*DW +: DW].
REQ-008 m_ready  output  N  SHALL carry the per-master ready back to each master.
REQ-009 s_valid  output  1  SHALL be the valid toward the shared slave.
REQ-010 s_data  output  DW  SHALL be the data toward the shared slave.
REQ-011 s_ready  input  1  SHALL be the ready from the shared slave.
REQ-012 grant  output  N  SHALL be the one-hot registered grant; all-zero when idle.
REQ-013 busy  output  1  SHALL be high exactly when the FSM is in BUSY.

Function
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 In IDLE, with any m_valid bit high at a rising edge, the FSM SHALL select the first set bit searching upward from rr_ptr (mod N), load grant one-hot, clear beat_cnt and enter BUSY on that edge.
REQ-016 The arbitration latency SHALL be one edge: m_valid sampled high at edge k gives grant and busy visible after edge k.
REQ-017 In IDLE the outputs SHALL be s_valid=0, s_data=0 and m_ready=0.
REQ-018 In BUSY with granted index g, s_valid SHALL equal m_valid[g] combinationally.
REQ-019 In BUSY, s_data SHALL equal m_data[g] when s_valid=1 and 0 otherwise.
REQ-020 In BUSY, m_ready[g] SHALL equal s_ready and every other m_ready bit SHALL be 0.
REQ-021 A beat SHALL be defined as s_valid & s_ready at a rising edge; each beat increments beat_cnt, which is 8 bits wide, saturating and never wrapping.
REQ-022 BUSY SHALL exit to IDLE at the edge where m_valid[g]=0 is sampled (release).
REQ-023 BUSY SHALL exit to IDLE at the edge where a beat brings beat_cnt to MAX_BEATS (forced release).
REQ-024 If release and forced release coincide, a single exit SHALL occur; that beat still counts as transferred.
REQ-025 On any exit, grant SHALL clear and rr_ptr SHALL load (g+1) mod N, wrapping from N-1 to 0.
REQ-026 After every exit, one IDLE cycle (bubble) SHALL occur before the next grant; re-arbitration happens at the following edge.
REQ-027 Requests from non-granted masters SHALL be ignored while BUSY and SHALL NOT alter rr_ptr.
REQ-028 A master whose m_valid drops while not granted SHALL lose no state; no request is latched.
REQ-029 s_ready high while s_valid=0 SHALL NOT count as a beat.

Reset
REQ-030 While rst_n=0: state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0, s_valid=0, s_data=0, m_ready=0, taking effect immediately without waiting for a clock edge.
REQ-031 Reset asserted mid-burst SHALL abort the grant with no further beat; after release, the first arbitration SHALL start from master 0.
REQ-032 Deassertion of rst_n SHALL be sampled synchronously; the first arbitration SHALL occur no earlier than the first rising edge after release.

Verification
REQ-033 Single requester: master 2 holds valid for 5 cycles, s_ready=1 -> grant=0100 one edge later, 4 beats with s_data=m_data[2], then IDLE and rr_ptr=3.
REQ-034 Round robin: all four m_valid held high, each master held for 3 beats, then valid dropped -> grant order 0,1,2,3,0, with one bubble cycle between grants.
REQ-035 Forced release: MAX_BEATS=4, master 1 holds valid, s_ready=1 -> exactly 4 beats, exit, then master 1 re-granted after the bubble only if no other master is requesting.
REQ-036 Backpressure: s_ready toggled 1,0,0,1 during a grant -> beat_cnt counts only ready-high edges, and m_ready of non-granted masters stays 0 throughout.
REQ-037 Coincident exit: m_valid[g] drops on the same edge as the MAX_BEATS-th beat -> exactly one exit and rr_ptr advances once.
REQ-038 Reset mid-burst: rst_n pulsed low for 3 ns while master 3 is granted -> grant and s_valid go 0 immediately, and the next grant after release goes to master 0 when masters 0 and 3 both request.
